alu_cmd_sequencer: RTL and testbench

// - Upstream command stage for the 32-bit ALU (add/sub/and/or, V/C/N/Z flags): accepts one op per handshake,

---
 rtl/alu_seq_pkg.sv | 50 +++++
 rtl/alu_cmd_sequencer_cond_check.sv | 42 ++++
 rtl/alu_cmd_sequencer.sv | 159 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared types and condition-code constants for the ALU
//                command sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2,
      RESP = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_OR  = 2'b11
   } alu_op_t;

   // Bit order matches the architectural flags port {N,Z,C,V}.
   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   localparam logic [3:0] c_cond_eq = 4'h0;
   localparam logic [3:0] c_cond_ne = 4'h1;
   localparam logic [3:0] c_cond_cs = 4'h2;
   localparam logic [3:0] c_cond_cc = 4'h3;
   localparam logic [3:0] c_cond_mi = 4'h4;
   localparam logic [3:0] c_cond_pl = 4'h5;
   localparam logic [3:0] c_cond_vs = 4'h6;
   localparam logic [3:0] c_cond_vc = 4'h7;
   localparam logic [3:0] c_cond_hi = 4'h8;
   localparam logic [3:0] c_cond_ls = 4'h9;
   localparam logic [3:0] c_cond_ge = 4'hA;
   localparam logic [3:0] c_cond_lt = 4'hB;
   localparam logic [3:0] c_cond_gt = 4'hC;
   localparam logic [3:0] c_cond_le = 4'hD;
   localparam logic [3:0] c_cond_al = 4'hE;
   localparam logic [3:0] c_cond_nv = 4'hF;

endpackage
`default_nettype wire

// File: rtl/alu_cmd_sequencer_cond_check.sv
`default_nettype none
// ============================================================================
//  Module      : cond_check
//  Description : Combinational ARM-style condition evaluation on NZCV.
//  Revision    : 1.0  initial release
// ============================================================================
module cond_check
   import alu_seq_pkg::*;
(
   input  logic [3:0] i_cond,
   input  logic [3:0] i_flags,
   output logic       o_pass
);

   flags_t w_f;
   assign w_f = flags_t'(i_flags);

   always_comb begin
      o_pass = 1'b1;
      case (i_cond)
         c_cond_eq: o_pass = w_f.z;
         c_cond_ne: o_pass = !w_f.z;
         c_cond_cs: o_pass = w_f.c;
         c_cond_cc: o_pass = !w_f.c;
         c_cond_mi: o_pass = w_f.n;
         c_cond_pl: o_pass = !w_f.n;
         c_cond_vs: o_pass = w_f.v;
         c_cond_vc: o_pass = !w_f.v;
         c_cond_hi: o_pass = w_f.c && !w_f.z;
         c_cond_ls: o_pass = !w_f.c || w_f.z;
         c_cond_ge: o_pass = (w_f.n == w_f.v);
         c_cond_lt: o_pass = (w_f.n != w_f.v);
         c_cond_gt: o_pass = !w_f.z && (w_f.n == w_f.v);
         c_cond_le: o_pass = w_f.z || (w_f.n != w_f.v);
         // The reserved NV encoding executes unconditionally.
         c_cond_al, c_cond_nv: o_pass = 1'b1;
         default:   o_pass = 1'b1;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_sequencer
//  Description : One-in-flight command stage for an external ALU: operand
//                fetch, conditional writeback, NZCV upkeep, response channel.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_cmd_sequencer
   import alu_seq_pkg::*;
#(
   parameter int N    = 32,
   parameter int NREG = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [1:0]              cmd_op,
   input  logic [$clog2(NREG)-1:0] cmd_rd,
   input  logic [$clog2(NREG)-1:0] cmd_ra,
   input  logic [$clog2(NREG)-1:0] cmd_rb,
   input  logic [3:0]              cmd_cond,
   input  logic                    cmd_setf,
   input  logic                    reg_we,
   input  logic [$clog2(NREG)-1:0] reg_waddr,
   input  logic [N-1:0]            reg_wdata,
   output logic [N-1:0]            alu_a,
   output logic [N-1:0]            alu_b,
   output logic [1:0]              alu_control,
   input  logic [N-1:0]            alu_result,
   input  logic                    alu_v,
   input  logic                    alu_c,
   input  logic                    alu_n,
   input  logic                    alu_z,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [N-1:0]            rsp_result,
   output logic                    rsp_skipped,
   output logic [3:0]              flags
);

   localparam int RW = $clog2(NREG);

   state_t        r_state;
   state_t        w_state_next;
   alu_op_t       r_op;
   logic [RW-1:0] r_rd;
   logic [3:0]    r_cond;
   logic          r_setf;
   logic [N-1:0]  r_a;
   logic [N-1:0]  r_b;
   logic [N-1:0]  r_res;
   logic [N-1:0]  r_rsp_result;
   logic          r_skipped;
   flags_t        r_flg;
   flags_t        r_flags;
   logic [N-1:0]  r_regs [NREG];

   logic          w_accept;
   logic          w_pass;
   logic          w_wb_we;

   cond_check u_cond_check (
      .i_cond  (r_cond),
      .i_flags (r_flags),
      .o_pass  (w_pass)
   );

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_wb_we      = 1'b0;
      case (r_state)
         IDLE: begin
            if (cmd_valid) begin
               w_accept     = 1'b1;
               w_state_next = EXEC;
            end
         end
         EXEC: w_state_next = WB;
         WB: begin
            w_wb_we      = w_pass;
            w_state_next = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_op         <= ALU_ADD;
         r_rd         <= '0;
         r_cond       <= '0;
         r_setf       <= 1'b0;
         r_a          <= '0;
         r_b          <= '0;
         r_res        <= '0;
         r_flg        <= '0;
         r_flags      <= '0;
         r_rsp_result <= '0;
         r_skipped    <= 1'b0;
      end else begin
         r_state <= w_state_next;
         // Operands are the ALU inputs themselves, so they hold between commands.
         if (w_accept) begin
            r_op   <= alu_op_t'(cmd_op);
            r_rd   <= cmd_rd;
            r_cond <= cmd_cond;
            r_setf <= cmd_setf;
            r_a    <= r_regs[cmd_ra];
            r_b    <= r_regs[cmd_rb];
         end
         if (r_state == EXEC) begin
            r_res <= alu_result;
            r_flg <= '{n: alu_n, z: alu_z, c: alu_c, v: alu_v};
         end
         if (r_state == WB) begin
            r_rsp_result <= r_res;
            r_skipped    <= !w_pass;
            if (w_pass && r_setf) begin
               r_flags <= r_flg;
            end
         end
      end
   end

   // Writeback is ordered after the host write so it wins on an address clash.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         if (reg_we) begin
            r_regs[reg_waddr] <= reg_wdata;
         end
         if (w_wb_we) begin
            r_regs[r_rd] <= r_res;
         end
      end
   end

   assign cmd_ready   = (r_state == IDLE);
   assign rsp_valid   = (r_state == RESP);
   assign rsp_result  = r_rsp_result;
   assign rsp_skipped = r_skipped;
   assign flags       = r_flags;
   assign alu_a       = r_a;
   assign alu_b       = r_b;
   assign alu_control = r_op;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_cmd_sequencer
//  Description : Directed bench for alu_cmd_sequencer with a behavioural ALU.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_cmd_sequencer;

   localparam int N    = 32;
   localparam int NREG = 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = '0;
   logic [2:0]    cmd_rd = '0;
   logic [2:0]    cmd_ra = '0;
   logic [2:0]    cmd_rb = '0;
   logic [3:0]    cmd_cond = '0;
   logic          cmd_setf = 1'b0;
   logic          reg_we = 1'b0;
   logic [2:0]    reg_waddr = '0;
   logic [N-1:0]  reg_wdata = '0;
   logic [N-1:0]  alu_a;
   logic [N-1:0]  alu_b;
   logic [1:0]    alu_control;
   logic [N-1:0]  alu_result;
   logic          alu_v;
   logic          alu_c;
   logic          alu_n;
   logic          alu_z;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [N-1:0]  rsp_result;
   logic          rsp_skipped;
   logic [3:0]    flags;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   // Reference ALU: ARM carry semantics (C = no borrow on subtract).
   logic [N:0] w_sum;
   always_comb begin
      w_sum      = '0;
      alu_result = '0;
      alu_c      = 1'b0;
      alu_v      = 1'b0;
      case (alu_control)
         2'b00: begin
            w_sum      = {1'b0, alu_a} + {1'b0, alu_b};
            alu_result = w_sum[N-1:0];
            alu_c      = w_sum[N];
            alu_v      = (alu_a[N-1] == alu_b[N-1]) && (w_sum[N-1] != alu_a[N-1]);
         end
         2'b01: begin
            w_sum      = {1'b0, alu_a} + {1'b0, ~alu_b} + {{N{1'b0}}, 1'b1};
            alu_result = w_sum[N-1:0];
            alu_c      = w_sum[N];
            alu_v      = (alu_a[N-1] != alu_b[N-1]) && (w_sum[N-1] != alu_a[N-1]);
         end
         2'b10:   alu_result = alu_a & alu_b;
         default: alu_result = alu_a | alu_b;
      endcase
   end
   assign alu_n = alu_result[N-1];
   assign alu_z = (alu_result == '0);

   alu_cmd_sequencer #(.N(N), .NREG(NREG)) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_rd      (cmd_rd),
      .cmd_ra      (cmd_ra),
      .cmd_rb      (cmd_rb),
      .cmd_cond    (cmd_cond),
      .cmd_setf    (cmd_setf),
      .reg_we      (reg_we),
      .reg_waddr   (reg_waddr),
      .reg_wdata   (reg_wdata),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_control (alu_control),
      .alu_result  (alu_result),
      .alu_v       (alu_v),
      .alu_c       (alu_c),
      .alu_n       (alu_n),
      .alu_z       (alu_z),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_result  (rsp_result),
      .rsp_skipped (rsp_skipped),
      .flags       (flags)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic host_write(input logic [2:0] addr, input logic [31:0] data);
      reg_we    = 1'b1;
      reg_waddr = addr;
      reg_wdata = data;
      tick();
      reg_we    = 1'b0;
   endtask

   task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] ra,
                        input logic [2:0] rb, input logic [3:0] cond, input logic setf);
      cmd_op    = op;
      cmd_rd    = rd;
      cmd_ra    = ra;
      cmd_rb    = rb;
      cmd_cond  = cond;
      cmd_setf  = setf;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   // lat counts cycles after the accept cycle; first response cycle is 3.
   task automatic wait_rsp(output int lat);
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         tick();
         lat++;
      end
      if (!rsp_valid) check("rsp_timeout", {31'b0, rsp_valid}, 32'd1);
   endtask

   task automatic run(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] ra,
                      input logic [2:0] rb, input logic [3:0] cond, input logic setf,
                      output logic [31:0] res, output logic skp, output int lat);
      issue(op, rd, ra, rb, cond, setf);
      wait_rsp(lat);
      res = rsp_result;
      skp = rsp_skipped;
      tick();
   endtask

   // r0 is never written, so rX + r0 echoes rX back unchanged.
   task automatic read_reg(input logic [2:0] r, output logic [31:0] v);
      logic skp;
      int   lat;
      run(2'b00, r, r, 3'd0, 4'hE, 1'b0, v, skp, lat);
   endtask

   initial begin
      logic [31:0] res;
      logic        skp;
      int          lat;

      tick();
      check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_rsp_skipped", {31'b0, rsp_skipped}, 32'd0);
      check("rst_flags", {28'b0, flags}, 32'h0);
      check("rst_rsp_result", rsp_result, 32'h0);
      check("rst_alu_a", alu_a, 32'h0);
      check("rst_alu_ctl", {30'b0, alu_control}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // Signed overflow on add.
      host_write(3'd1, 32'h7FFF_FFFF);
      host_write(3'd2, 32'h0000_0001);
      run(2'b00, 3'd3, 3'd1, 3'd2, 4'hE, 1'b1, res, skp, lat);
      check("add_latency", lat, 32'd3);
      check("add_result", res, 32'h8000_0000);
      check("add_skipped", {31'b0, skp}, 32'd0);
      check("add_flags", {28'b0, flags}, 32'h9);
      check("alu_a_hold", alu_a, 32'h7FFF_FFFF);
      check("alu_b_hold", alu_b, 32'h0000_0001);
      read_reg(3'd3, res);
      check("r3_written", res, 32'h8000_0000);
      check("flags_no_setf", {28'b0, flags}, 32'h9);

      // SUB to zero, then EQ passes.
      host_write(3'd4, 32'd5);
      run(2'b01, 3'd5, 3'd4, 3'd4, 4'hE, 1'b1, res, skp, lat);
      check("sub_result", res, 32'h0);
      check("sub_flags", {28'b0, flags}, 32'h6);
      run(2'b00, 3'd6, 3'd4, 3'd4, 4'h0, 1'b0, res, skp, lat);
      check("eq_add_result", res, 32'h0000_000A);
      check("eq_add_skipped", {31'b0, skp}, 32'd0);
      read_reg(3'd5, res);
      check("r5_zero", res, 32'h0);
      read_reg(3'd6, res);
      check("r6_ten", res, 32'h0000_000A);

      // Make Z=0 (N=1), then conditions that fail.
      run(2'b00, 3'd3, 3'd3, 3'd0, 4'hE, 1'b1, res, skp, lat);
      check("nz_flags", {28'b0, flags}, 32'h8);
      run(2'b11, 3'd7, 3'd1, 3'd2, 4'h0, 1'b1, res, skp, lat);
      check("eq_fail_skipped", {31'b0, skp}, 32'd1);
      check("eq_fail_result", res, 32'h7FFF_FFFF);
      check("eq_fail_flags", {28'b0, flags}, 32'h8);
      read_reg(3'd7, res);
      check("r7_unchanged", res, 32'h0);
      run(2'b00, 3'd7, 3'd0, 3'd2, 4'hA, 1'b0, res, skp, lat);
      check("ge_fail_skipped", {31'b0, skp}, 32'd1);
      check("ge_fail_result", res, 32'h1);
      run(2'b11, 3'd7, 3'd1, 3'd2, 4'h1, 1'b1, res, skp, lat);
      check("ne_pass_skipped", {31'b0, skp}, 32'd0);
      check("ne_pass_flags", {28'b0, flags}, 32'h0);
      read_reg(3'd7, res);
      check("r7_or", res, 32'h7FFF_FFFF);

      // Response backpressure.
      rsp_ready = 1'b0;
      issue(2'b00, 3'd6, 3'd2, 3'd2, 4'hE, 1'b0);
      wait_rsp(lat);
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", {31'b0, rsp_valid}, 32'd1);
         check("stall_result", rsp_result, 32'h2);
         check("stall_cmd_ready", {31'b0, cmd_ready}, 32'd0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      check("release_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      check("release_rsp_valid", {31'b0, rsp_valid}, 32'd0);

      // Host write colliding with writeback: writeback wins.
      issue(2'b00, 3'd3, 3'd4, 3'd4, 4'hE, 1'b0);
      tick();
      host_write(3'd3, 32'hDEAD_BEEF);
      check("wb_clash_rsp", rsp_result, 32'h0000_000A);
      tick();
      read_reg(3'd3, res);
      check("wb_clash_r3", res, 32'h0000_000A);

      // Host write in the accept cycle: operand sees the old value.
      reg_we    = 1'b1;
      reg_waddr = 3'd2;
      reg_wdata = 32'h0000_0100;
      issue(2'b00, 3'd5, 3'd2, 3'd0, 4'hE, 1'b0);
      reg_we    = 1'b0;
      wait_rsp(lat);
      check("accept_old_operand", rsp_result, 32'h1);
      tick();
      read_reg(3'd2, res);
      check("r2_host_new", res, 32'h0000_0100);

      // Nonzero flags, then reset in the middle of EXEC.
      run(2'b01, 3'd6, 3'd0, 3'd2, 4'hE, 1'b1, res, skp, lat);
      check("neg_result", res, 32'hFFFF_FF00);
      check("neg_flags", {28'b0, flags}, 32'h8);
      issue(2'b00, 3'd5, 3'd1, 3'd1, 4'hE, 1'b1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("mid_rst_flags", {28'b0, flags}, 32'h0);
      check("mid_rst_alu_a", alu_a, 32'h0);
      check("mid_rst_rsp_result", rsp_result, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      check("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      read_reg(3'd5, res);
      check("post_rst_r5", res, 32'h0);
      read_reg(3'd1, res);
      check("post_rst_r1", res, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
